// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: DEPTH-entry circular capture of {pc, instr, alu, mem}
// samples from the datapath debug taps. Capture starts at once or on a PC
// match. It stops when the buffer is full, or keeps overwriting the oldest
// entry in wrap mode. Once stopped, entries are read back oldest-first.
module exec_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter bit MODE_WRAP = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_pc,
    input  logic [DATA_W-1:0] cap_instr,
    input  logic [DATA_W-1:0] cap_alu,
    input  logic [DATA_W-1:0] cap_mem,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_instr,
    output logic [DATA_W-1:0] rd_alu,
    output logic [DATA_W-1:0] rd_mem,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              overflow
);
    localparam int              DEPTH  = 1 << ADDR_W;
    localparam int              ENT_W  = 4 * DATA_W;
    localparam logic [ADDR_W:0] FULL_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ENT_W-1:0]    ram_r [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic [ADDR_W:0]     count_r;
    logic                overflow_r;
    logic                rd_valid_r;
    logic                done_r;
    logic [DATA_W-1:0]   rd_pc_r;
    logic [DATA_W-1:0]   rd_instr_r;
    logic [DATA_W-1:0]   rd_alu_r;
    logic [DATA_W-1:0]   rd_mem_r;
    logic                wr_en_s;
    logic                rd_en_s;
    logic                hit_s;
    logic                full_s;
    logic                last_slot_s;
    logic [ENT_W-1:0]    wr_data_s;
    logic [ENT_W-1:0]    rd_data_s;

    assign hit_s       = cap_valid && (cap_pc == trig_pc);
    assign full_s      = (count_r == FULL_C);
    assign last_slot_s = (count_r == LAST_C);
    assign wr_data_s   = {cap_pc, cap_instr, cap_alu, cap_mem};
    assign rd_data_s   = ram_r[rd_ptr_r];

    // Next-state, write-enable and read-enable decode; arm overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        wr_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        if (arm) begin
            state_nxt_s = trig_en ? ARMED : CAPTURE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                ARMED: begin
                    if (hit_s) begin
                        // The triggering sample itself becomes entry 0.
                        wr_en_s = 1'b1;
                        if (stop || (last_slot_s && !MODE_WRAP)) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = CAPTURE;
                        end
                    end else if (stop) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end
                CAPTURE: begin
                    if (cap_valid && (!full_s || MODE_WRAP)) begin
                        wr_en_s = 1'b1;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    // Non-wrap capture ends on the write that fills the last slot.
                    if (stop || (wr_en_s && last_slot_s && !MODE_WRAP)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CAPTURE;
                    end
                end
                DONE: begin
                    state_nxt_s = DONE;
                    rd_en_s     = rd_req && (count_r != {(ADDR_W + 1){1'b0}});
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State register plus the registered done flag that mirrors it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Trace RAM write port; contents are left uninitialised on reset.
    always_ff @(posedge clock) begin
        if (wr_en_s && !reset) begin
            ram_r[wr_ptr_r] <= wr_data_s;
        end
    end

    // Pointers, occupancy and sticky overflow; a write at full drops the oldest entry.
    always_ff @(posedge clock) begin
        if (reset || arm) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {(ADDR_W + 1){1'b0}};
            overflow_r <= 1'b0;
        end else if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            if (full_s) begin
                rd_ptr_r   <= rd_ptr_r + ADDR_W'(1);
                overflow_r <= 1'b1;
            end else begin
                count_r <= count_r + (ADDR_W + 1)'(1);
            end
        end else if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            count_r  <= count_r - (ADDR_W + 1)'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Read-out port: single-cycle valid pulse, data held between pops.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_pc_r    <= {DATA_W{1'b0}};
            rd_instr_r <= {DATA_W{1'b0}};
            rd_alu_r   <= {DATA_W{1'b0}};
            rd_mem_r   <= {DATA_W{1'b0}};
        end else begin
            rd_valid_r <= rd_en_s;
            if (rd_en_s) begin
                {rd_pc_r, rd_instr_r, rd_alu_r, rd_mem_r} <= rd_data_s;
            end
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_pc    = rd_pc_r;
    assign rd_instr = rd_instr_r;
    assign rd_alu   = rd_alu_r;
    assign rd_mem   = rd_mem_r;
    assign count    = count_r;
    assign done     = done_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Bench for exec_trace_buffer. A stop-when-full instance and a wrap instance
// share one stimulus stream. Both are compared every cycle against a
// queue-based model of the capture rules. Literal expectations pin the
// directed scenarios.
module tb_exec_trace_buffer;
    localparam int DEPTH = 16;
    localparam int S_IDLE = 0, S_ARMED = 1, S_CAP = 2, S_DONE = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] mem;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = 32'd0;
    logic        cap_valid = 1'b0;
    logic [31:0] cap_pc = 32'd0;
    logic [31:0] cap_instr = 32'd0;
    logic [31:0] cap_alu = 32'd0;
    logic [31:0] cap_mem = 32'd0;
    logic        rd_req = 1'b0;

    logic        rv_o   [2];
    logic [31:0] pc_o   [2];
    logic [31:0] ins_o  [2];
    logic [31:0] alu_o  [2];
    logic [31:0] mem_o  [2];
    logic [4:0]  cnt_o  [2];
    logic        done_o [2];
    logic        ovf_o  [2];

    int n_cmp = 0;
    int n_bad = 0;

    // model state per instance (0 = stop when full, 1 = wrap)
    ent_t mq [2][$];
    int   mst  [2];
    bit   movf [2];
    bit   mrv  [2];
    ent_t mlast[2];

    always #5 clk = ~clk;

    exec_trace_buffer #(.DATA_W(32), .ADDR_W(4), .MODE_WRAP(1'b0)) u_stop (
        .clock(clk), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en),
        .trig_pc(trig_pc), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_instr(cap_instr), .cap_alu(cap_alu), .cap_mem(cap_mem),
        .rd_req(rd_req), .rd_valid(rv_o[0]), .rd_pc(pc_o[0]),
        .rd_instr(ins_o[0]), .rd_alu(alu_o[0]), .rd_mem(mem_o[0]),
        .count(cnt_o[0]), .done(done_o[0]), .overflow(ovf_o[0])
    );

    exec_trace_buffer #(.DATA_W(32), .ADDR_W(4), .MODE_WRAP(1'b1)) u_wrap (
        .clock(clk), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en),
        .trig_pc(trig_pc), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_instr(cap_instr), .cap_alu(cap_alu), .cap_mem(cap_mem),
        .rd_req(rd_req), .rd_valid(rv_o[1]), .rd_pc(pc_o[1]),
        .rd_instr(ins_o[1]), .rd_alu(alu_o[1]), .rd_mem(mem_o[1]),
        .count(cnt_o[1]), .done(done_o[1]), .overflow(ovf_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the specification's rules applied to instance m.
    task automatic model_step(input int m);
        bit   wrap;
        ent_t e;
        wrap = (m == 1);
        e = '{pc: cap_pc, instr: cap_instr, alu: cap_alu, mem: cap_mem};
        mrv[m] = 1'b0;
        if (reset) begin
            mq[m].delete();
            mst[m] = S_IDLE;
            movf[m] = 1'b0;
            mlast[m] = '0;
        end else if (arm) begin
            mq[m].delete();
            movf[m] = 1'b0;
            mst[m] = trig_en ? S_ARMED : S_CAP;
        end else if (mst[m] == S_ARMED) begin
            if (cap_valid && cap_pc == trig_pc) begin
                mq[m].push_back(e);
                mst[m] = S_CAP;
            end
            if (stop) mst[m] = S_DONE;
        end else if (mst[m] == S_CAP) begin
            if (cap_valid) begin
                if (mq[m].size() < DEPTH) begin
                    mq[m].push_back(e);
                end else if (wrap) begin
                    void'(mq[m].pop_front());
                    mq[m].push_back(e);
                    movf[m] = 1'b1;
                end
            end
            if (stop || (!wrap && mq[m].size() == DEPTH)) mst[m] = S_DONE;
        end else if (mst[m] == S_DONE) begin
            if (rd_req && mq[m].size() > 0) begin
                mlast[m] = mq[m].pop_front();
                mrv[m] = 1'b1;
            end
        end
    endtask

    task automatic compare(input int m);
        chk($sformatf("m%0d rd_valid", m), 32'(rv_o[m]), 32'(mrv[m]));
        chk($sformatf("m%0d count", m), 32'(cnt_o[m]), 32'(mq[m].size()));
        chk($sformatf("m%0d done", m), 32'(done_o[m]), 32'(mst[m] == S_DONE));
        chk($sformatf("m%0d overflow", m), 32'(ovf_o[m]), 32'(movf[m]));
        chk($sformatf("m%0d rd_pc", m), pc_o[m], mlast[m].pc);
        chk($sformatf("m%0d rd_instr", m), ins_o[m], mlast[m].instr);
        chk($sformatf("m%0d rd_alu", m), alu_o[m], mlast[m].alu);
        chk($sformatf("m%0d rd_mem", m), mem_o[m], mlast[m].mem);
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m);
        #1;
        for (int m = 0; m < 2; m++) compare(m);
    endtask

    task automatic clear_pulses();
        arm = 1'b0; stop = 1'b0; cap_valid = 1'b0; rd_req = 1'b0; reset = 1'b0;
    endtask

    task automatic sample(input logic [31:0] pc);
        cap_valid = 1'b1;
        cap_pc    = pc;
        cap_instr = $urandom;
        cap_alu   = $urandom;
        cap_mem   = $urandom;
        cyc();
        clear_pulses();
    endtask

    task automatic do_arm(input logic te, input logic [31:0] tp);
        arm = 1'b1; trig_en = te; trig_pc = tp;
        cyc();
        clear_pulses();
    endtask

    initial begin
        reset = 1'b1;
        cyc();
        cyc();
        chk("reset count", 32'(cnt_o[0]), 32'd0);
        chk("reset done", 32'(done_o[1]), 32'd0);
        clear_pulses();

        // 1: stop-when-full, immediate capture, read-back in order
        do_arm(1'b0, 32'd0);
        for (int i = 0; i < 20; i++) sample(32'(4 * i));
        chk("s1 done", 32'(done_o[0]), 32'd1);
        chk("s1 count", 32'(cnt_o[0]), 32'd16);
        for (int k = 0; k < 17; k++) begin
            rd_req = 1'b1;
            cyc();
            clear_pulses();
            if (k < 16) begin
                chk("s1 rd_valid", 32'(rv_o[0]), 32'd1);
                chk("s1 rd_pc", pc_o[0], 32'(4 * k));
            end else begin
                chk("s1 rd_valid empty", 32'(rv_o[0]), 32'd0);
            end
        end

        // 2: PC-match trigger
        do_arm(1'b1, 32'h20);
        for (int i = 0; i < 30; i++) sample(32'(4 * i));
        chk("s2 count", 32'(cnt_o[0]), 32'd16);
        chk("s2 done", 32'(done_o[0]), 32'd1);
        rd_req = 1'b1;
        cyc();
        clear_pulses();
        chk("s2 first pc", pc_o[0], 32'h20);

        // 3: wrap mode overwrite then stop
        do_arm(1'b0, 32'd0);
        for (int i = 0; i < 20; i++) sample(32'(4 * i));
        stop = 1'b1;
        cyc();
        clear_pulses();
        chk("s3 overflow", 32'(ovf_o[1]), 32'd1);
        chk("s3 count", 32'(cnt_o[1]), 32'd16);
        for (int k = 0; k < 16; k++) begin
            rd_req = 1'b1;
            cyc();
            clear_pulses();
            chk("s3 rd_pc", pc_o[1], 32'(32'h10 + 4 * k));
        end

        // 4: stop with a sample, then arm+stop together
        do_arm(1'b0, 32'd0);
        sample(32'h100);
        sample(32'h104);
        stop = 1'b1;
        sample(32'h108);
        chk("s4 count", 32'(cnt_o[0]), 32'd3);
        chk("s4 done", 32'(done_o[1]), 32'd1);
        arm = 1'b1; stop = 1'b1; trig_en = 1'b0;
        cyc();
        clear_pulses();
        chk("s4 arm+stop count", 32'(cnt_o[0]), 32'd0);
        chk("s4 arm+stop done", 32'(done_o[0]), 32'd0);

        // 5: reset mid-capture
        do_arm(1'b0, 32'd0);
        for (int i = 0; i < 5; i++) sample(32'(4 * i));
        reset = 1'b1;
        cyc();
        clear_pulses();
        chk("s5 count", 32'(cnt_o[1]), 32'd0);
        chk("s5 done", 32'(done_o[1]), 32'd0);
        chk("s5 overflow", 32'(ovf_o[1]), 32'd0);
        chk("s5 rd_valid", 32'(rv_o[1]), 32'd0);

        // 6: rd_req while capturing is ignored
        do_arm(1'b0, 32'd0);
        for (int i = 0; i < 3; i++) sample(32'(4 * i));
        rd_req = 1'b1;
        cyc();
        clear_pulses();
        chk("s6 rd_valid", 32'(rv_o[0]), 32'd0);
        chk("s6 count", 32'(cnt_o[0]), 32'd3);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            arm       = ($urandom_range(0, 39) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            trig_en   = $urandom_range(0, 1);
            trig_pc   = 32'(4 * $urandom_range(0, 15));
            cap_valid = ($urandom_range(0, 9) < 6);
            cap_pc    = 32'(4 * $urandom_range(0, 15));
            cap_instr = $urandom;
            cap_alu   = $urandom;
            cap_mem   = $urandom;
            rd_req    = $urandom_range(0, 1);
            cyc();
        end
        clear_pulses();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
